// File: rtl/wb_port_arbiter_if.sv
// Register-file write-port bundle: pipeline writeback (A), long-latency result (B),
// regfile write, long-latency issue tracking and decode hazard lookup.
interface wb_port_arbiter_if #(
  parameter int REGIDX_WIDTH = 5,
  parameter int DATA_W       = 32
);
  logic                    a_valid;
  logic [REGIDX_WIDTH-1:0] a_rd;
  logic [DATA_W-1:0]       a_data;

  logic                    b_valid;
  logic                    b_ready;
  logic [REGIDX_WIDTH-1:0] b_rd;
  logic [DATA_W-1:0]       b_data;

  logic                    pipe_stall;

  logic                    rd_wen;
  logic [REGIDX_WIDTH-1:0] rd_addr;
  logic [DATA_W-1:0]       rd_data;

  logic                    issue_valid;
  logic [REGIDX_WIDTH-1:0] issue_rd;

  logic [REGIDX_WIDTH-1:0] rs1_addr;
  logic [REGIDX_WIDTH-1:0] rs2_addr;
  logic                    rs1_busy;
  logic                    rs2_busy;

  // Arbiter side
  modport slave (
    input  a_valid, a_rd, a_data,
    input  b_valid, b_rd, b_data,
    output b_ready,
    output pipe_stall,
    output rd_wen, rd_addr, rd_data,
    input  issue_valid, issue_rd,
    input  rs1_addr, rs2_addr,
    output rs1_busy, rs2_busy
  );

  // Writers / decode / regfile side
  modport master (
    output a_valid, a_rd, a_data,
    output b_valid, b_rd, b_data,
    input  b_ready,
    input  pipe_stall,
    input  rd_wen, rd_addr, rd_data,
    output issue_valid, issue_rd,
    output rs1_addr, rs2_addr,
    input  rs1_busy, rs2_busy
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the single regfile write port between pipeline writeback (A, priority) and a
// long-latency unit (B, valid/ready), with bounded B starvation and a pending-write scoreboard.
module wb_port_arbiter #(
  parameter int REGIDX_WIDTH = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  wb_port_arbiter_if.slave   bus
);

  localparam int NUM_REGS = 2 ** REGIDX_WIDTH;
  localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);
  localparam int DATA_W   = 32;

  typedef enum logic {ST_ARB, ST_FORCE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        cnt_nxt;
  logic [NUM_REGS-1:1]     pending;
  logic [NUM_REGS-1:1]     pending_nxt;
  logic [NUM_REGS-1:0]     pending_full;

  logic                    grant_a;
  logic                    grant_b;
  logic                    b_ready;
  logic                    b_hs;
  logic                    rd_wen;
  logic [REGIDX_WIDTH-1:0] rd_addr;
  logic [DATA_W-1:0]       rd_data;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_W'(STARVE_LIMIT)) ? v : v + 1'b1;
  endfunction

  // FORCE hands the port to B unconditionally; otherwise A has priority.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state == ST_FORCE)
      grant_b = bus.b_valid;
    else if (bus.a_valid)
      grant_a = 1'b1;
    else
      grant_b = bus.b_valid;
  end

  assign b_ready = (state == ST_FORCE) | ~bus.a_valid;
  assign b_hs    = bus.b_valid & b_ready;

  always_comb begin
    rd_wen  = 1'b0;
    rd_addr = '0;
    rd_data = '0;
    if (grant_a) begin
      rd_wen  = (bus.a_rd != '0);
      rd_addr = bus.a_rd;
      rd_data = bus.a_data;
    end else if (grant_b) begin
      rd_wen  = (bus.b_rd != '0);
      rd_addr = bus.b_rd;
      rd_data = bus.b_data;
    end
  end

  assign cnt_nxt = (~bus.b_valid | b_hs) ? '0 : sat_inc(cnt);

  // Issue is applied after retire so a same-edge issue to the retiring rd keeps it pending.
  always_comb begin
    pending_nxt = pending;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (b_hs && (bus.b_rd == REGIDX_WIDTH'(r)))
        pending_nxt[r] = 1'b0;
      if (bus.issue_valid && (bus.issue_rd == REGIDX_WIDTH'(r)))
        pending_nxt[r] = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state   <= ST_ARB;
      cnt     <= '0;
      pending <= '0;
    end else begin
      cnt     <= cnt_nxt;
      pending <= pending_nxt;
      unique case (state)
        ST_ARB:   if (cnt_nxt == CNT_W'(STARVE_LIMIT)) state <= ST_FORCE;
        ST_FORCE: if (b_hs || !bus.b_valid)            state <= ST_ARB;
        default:  state <= ST_ARB;
      endcase
    end
  end

  // Bit 0 is hard zero so x0 never reports a hazard.
  assign pending_full = {pending, 1'b0};

  assign bus.b_ready    = b_ready;
  assign bus.pipe_stall = (state == ST_FORCE) & bus.a_valid;
  assign bus.rd_wen     = rd_wen;
  assign bus.rd_addr    = rd_addr;
  assign bus.rd_data    = rd_data;
  assign bus.rs1_busy   = pending_full[bus.rs1_addr];
  assign bus.rs2_busy   = pending_full[bus.rs2_addr];

  // Protocol checks on the issue/retire bookkeeping and the B handshake.
  logic b_blocked;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)
      b_blocked <= 1'b0;
    else
      b_blocked <= bus.b_valid & ~b_ready;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (bus.issue_valid && (bus.issue_rd != '0))
        assert (!pending_full[bus.issue_rd] || (b_hs && (bus.b_rd == bus.issue_rd)));
      if (b_hs && (bus.b_rd != '0))
        assert (pending_full[bus.b_rd]);
      if (b_blocked)
        assert (bus.b_valid);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: stimulus pushes expected port state into a queue,
// a negedge monitor pops and compares.
module tb_wb_port_arbiter;

  logic clk;
  logic rst_n;

  wb_port_arbiter_if #(.REGIDX_WIDTH(5), .DATA_W(32)) bus ();

  wb_port_arbiter #(
    .REGIDX_WIDTH(5),
    .STARVE_LIMIT(4)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {rd_wen, rd_addr, rd_data, b_ready, pipe_stall, rs1_busy, rs2_busy}
  typedef struct {
    string       name;
    logic [41:0] exp;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;

  function automatic logic [41:0] ev(input logic wen, input logic [4:0] addr,
                                     input logic [31:0] data, input logic br,
                                     input logic st, input logic b1, input logic b2);
    return {wen, addr, data, br, st, b1, b2};
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      item_t       it;
      logic [41:0] act;
      it  = q.pop_front();
      act = {bus.rd_wen, bus.rd_addr, bus.rd_data, bus.b_ready, bus.pipe_stall,
             bus.rs1_busy, bus.rs2_busy};
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got wen=%b addr=%0d data=%h bready=%b stall=%b busy=%b%b, want wen=%b addr=%0d data=%h bready=%b stall=%b busy=%b%b",
                 it.name, act[41], act[40:36], act[35:4], act[3], act[2], act[1], act[0],
                 it.exp[41], it.exp[40:36], it.exp[35:4], it.exp[3], it.exp[2], it.exp[1], it.exp[0]);
      end
    end
  end

  task automatic set_in(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                        input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                        input logic iv, input logic [4:0] ird,
                        input logic [4:0] rs1, input logic [4:0] rs2);
    bus.a_valid     = av;
    bus.a_rd        = ard;
    bus.a_data      = ad;
    bus.b_valid     = bv;
    bus.b_rd        = brd;
    bus.b_data      = bd;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    bus.rs1_addr    = rs1;
    bus.rs2_addr    = rs2;
  endtask

  task automatic step(input string nm, input logic [41:0] e);
    item_t it;
    it.name = nm;
    it.exp  = e;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    step("reset", ev(0, 0, 0, 1, 0, 0, 0));
    rst_n = 1'b1;
    step("idle", ev(0, 0, 0, 1, 0, 0, 0));

    // A only
    set_in(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
    step("a_only", ev(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 0));

    // B only with scoreboard
    set_in(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step("issue7", ev(0, 0, 0, 1, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step("busy7", ev(0, 0, 0, 1, 0, 1, 0));
    set_in(0, 0, 0, 1, 7, 32'h1234, 0, 0, 7, 0);
    step("b_write7", ev(1, 7, 32'h1234, 1, 0, 1, 0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 7, 0);
    step("busy7_clr", ev(0, 0, 0, 1, 0, 0, 0));

    // Starvation: four A wins, then forced B, then A again
    set_in(0, 0, 0, 0, 0, 0, 1, 12, 12, 0);
    step("issue12", ev(0, 0, 0, 1, 0, 0, 0));
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 3, 32'h100 + i, 1, 12, 32'hB0B, 0, 0, 12, 0);
      step("starve_a", ev(1, 3, 32'h100 + i, 0, 0, 1, 0));
    end
    set_in(1, 3, 32'h105, 1, 12, 32'hB0B, 0, 0, 12, 0);
    step("force_b", ev(1, 12, 32'hB0B, 1, 1, 1, 0));
    set_in(1, 3, 32'h105, 0, 0, 0, 0, 0, 12, 0);
    step("a_after_force", ev(1, 3, 32'h105, 0, 0, 0, 0));

    // x0 writes
    set_in(1, 0, 32'h55, 0, 0, 0, 0, 0, 0, 0);
    step("a_x0", ev(0, 0, 32'h55, 0, 0, 0, 0));
    set_in(0, 0, 0, 1, 0, 32'h77, 1, 4, 4, 0);
    step("b_x0", ev(0, 0, 32'h77, 1, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 4, 0);
    step("busy4", ev(0, 0, 0, 1, 0, 1, 0));
    set_in(0, 0, 0, 1, 4, 32'h44, 0, 0, 4, 0);
    step("b_write4", ev(1, 4, 32'h44, 1, 0, 1, 0));

    // Same-edge issue and retire of x9
    set_in(0, 0, 0, 0, 0, 0, 1, 9, 4, 9);
    step("issue9", ev(0, 0, 0, 1, 0, 0, 0));
    set_in(0, 0, 0, 1, 9, 32'h99, 1, 9, 9, 0);
    step("issue_retire9", ev(1, 9, 32'h99, 1, 0, 1, 0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
    step("busy9_kept", ev(0, 0, 0, 1, 0, 1, 0));

    // Reset while in FORCE with x7 and x9 pending
    set_in(0, 0, 0, 0, 0, 0, 1, 7, 7, 9);
    step("issue7b", ev(0, 0, 0, 1, 0, 0, 1));
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 1, i, 1, 7, 32'h777, 0, 0, 7, 9);
      step("starve_a2", ev(1, 1, i, 0, 0, 1, 1));
    end
    rst_n = 1'b0;
    set_in(1, 1, 5, 1, 7, 32'h777, 0, 0, 7, 9);
    step("force_in_rst", ev(1, 7, 32'h777, 1, 1, 1, 1));
    rst_n = 1'b1;
    set_in(1, 1, 5, 0, 0, 0, 0, 0, 7, 9);
    step("after_rst", ev(1, 1, 5, 0, 0, 0, 0));
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("final_idle", ev(0, 0, 0, 1, 0, 0, 0));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
